tap_controller: RTL and testbench

// - IEEE 1149.1-style TAP controller for the boundary-scan test logic.
// - Runs the 16-state TAP FSM from tms, owns the instruction register (IR)
//   and drives the instruction bus into the instruction decoder.
// - Sequences the data registers: boundary scan for EXTEST, SAMPLE_PRELOAD
//   and INTEST, and bypass for BYPASS. Muxes the IR or DR serial output onto tdo.

---
 rtl/tap_controller.sv | 122 ++++++++++++
 tb/tb_tap_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tap_controller.sv
// IEEE 1149.1-style TAP controller: 16-state FSM, instruction register and tdo mux.
// Define TAP_STATE_OUT_EN to expose the state register on tapState for debug.
module tap_controller #(
  parameter int                    IR_WIDTH   = 2,
  parameter logic [IR_WIDTH-1:0]   IR_CAPTURE = 2'b01,
  parameter logic [IR_WIDTH-1:0]   IR_RESET   = 2'd3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tms,
  input  logic                tdi,
  input  logic                drTdo,
  output logic [IR_WIDTH-1:0] instruction,
  output logic                captureDR,
  output logic                shiftDR,
  output logic                updateDR,
  output logic                tdo,
  output logic                tdoEn
`ifdef TAP_STATE_OUT_EN
  ,
  output logic [3:0]          tapState
`endif
);

  typedef enum logic [3:0] {
    TLR     = 4'hF,
    RTI     = 4'hC,
    SEL_DR  = 4'h7,
    CAP_DR  = 4'h6,
    SH_DR   = 4'h2,
    EX1_DR  = 4'h1,
    PAUSE_DR = 4'h3,
    EX2_DR  = 4'h0,
    UPD_DR  = 4'h5,
    SEL_IR  = 4'h4,
    CAP_IR  = 4'hE,
    SH_IR   = 4'hA,
    EX1_IR  = 4'h9,
    PAUSE_IR = 4'hB,
    EX2_IR  = 4'h8,
    UPD_IR  = 4'hD
  } state_t;

  state_t              state_q, state_d;
  logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
  logic [IR_WIDTH-1:0] instr_q, instr_d;
  logic                tdo_q, tdo_d;
  logic                tdo_en_q, tdo_en_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= TLR;
      ir_shift_q <= '0;
      instr_q    <= IR_RESET;
      tdo_q      <= 1'b0;
      tdo_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_shift_q <= ir_shift_d;
      instr_q    <= instr_d;
      tdo_q      <= tdo_d;
      tdo_en_q   <= tdo_en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:      state_d = tms ? TLR    : RTI;
      RTI:      state_d = tms ? SEL_DR : RTI;
      SEL_DR:   state_d = tms ? SEL_IR : CAP_DR;
      CAP_DR:   state_d = tms ? EX1_DR : SH_DR;
      SH_DR:    state_d = tms ? EX1_DR : SH_DR;
      EX1_DR:   state_d = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: state_d = tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   state_d = tms ? UPD_DR : SH_DR;
      UPD_DR:   state_d = tms ? SEL_DR : RTI;
      SEL_IR:   state_d = tms ? TLR    : CAP_IR;
      CAP_IR:   state_d = tms ? EX1_IR : SH_IR;
      SH_IR:    state_d = tms ? EX1_IR : SH_IR;
      EX1_IR:   state_d = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: state_d = tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   state_d = tms ? UPD_IR : SH_IR;
      UPD_IR:   state_d = tms ? SEL_DR : RTI;
      default:  state_d = TLR;
    endcase
  end

  // IR shift stage, active instruction and registered tdo path
  always_comb begin
    ir_shift_d = ir_shift_q;
    instr_d    = instr_q;
    tdo_d      = 1'b0;
    tdo_en_d   = 1'b0;
    case (state_q)
      CAP_IR: ir_shift_d = IR_CAPTURE;
      SH_IR: begin
        ir_shift_d = {tdi, ir_shift_q[IR_WIDTH-1:1]};
        tdo_d      = ir_shift_q[0];
        tdo_en_d   = 1'b1;
      end
      SH_DR: begin
        tdo_d    = drTdo;
        tdo_en_d = 1'b1;
      end
      UPD_IR:  instr_d = ir_shift_q;
      TLR:     instr_d = IR_RESET;
      default: ;
    endcase
  end

  assign instruction = instr_q;
  assign captureDR   = (state_q == CAP_DR);
  assign shiftDR     = (state_q == SH_DR);
  assign updateDR    = (state_q == UPD_DR);
  assign tdo         = tdo_q;
  assign tdoEn       = tdo_en_q;
`ifdef TAP_STATE_OUT_EN
  assign tapState    = state_q;
`endif

endmodule

// File: tb/tb_tap_controller.sv
// Directed plus randomized bench for tap_controller against a state-name table model.
module tb_tap_controller;

  logic       clk = 1'b0;
  logic       rst, tms, tdi, drTdo;
  logic [1:0] instruction;
  logic       captureDR, shiftDR, updateDR, tdo, tdoEn;
`ifdef TAP_STATE_OUT_EN
  logic [3:0] tapState;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  string      m_state;
  logic [1:0] m_ir, m_instr;
  logic       m_tdo, m_tdoEn;

  tap_controller dut (
    .clk(clk), .rst(rst), .tms(tms), .tdi(tdi), .drTdo(drTdo),
    .instruction(instruction), .captureDR(captureDR), .shiftDR(shiftDR),
    .updateDR(updateDR), .tdo(tdo), .tdoEn(tdoEn)
`ifdef TAP_STATE_OUT_EN
    , .tapState(tapState)
`endif
  );

  always #5 clk = ~clk;

  function automatic string nxt(input string s, input logic t);
    case (s)
      "TLR":     return t ? "TLR"   : "RTI";
      "RTI":     return t ? "SelDR" : "RTI";
      "SelDR":   return t ? "SelIR" : "CapDR";
      "SelIR":   return t ? "TLR"   : "CapIR";
      "CapDR":   return t ? "Ex1DR" : "ShDR";
      "ShDR":    return t ? "Ex1DR" : "ShDR";
      "Ex1DR":   return t ? "UpdDR" : "PauseDR";
      "PauseDR": return t ? "Ex2DR" : "PauseDR";
      "Ex2DR":   return t ? "UpdDR" : "ShDR";
      "UpdDR":   return t ? "SelDR" : "RTI";
      "CapIR":   return t ? "Ex1IR" : "ShIR";
      "ShIR":    return t ? "Ex1IR" : "ShIR";
      "Ex1IR":   return t ? "UpdIR" : "PauseIR";
      "PauseIR": return t ? "Ex2IR" : "PauseIR";
      "Ex2IR":   return t ? "UpdIR" : "ShIR";
      "UpdIR":   return t ? "SelDR" : "RTI";
      default:   return "TLR";
    endcase
  endfunction

`ifdef TAP_STATE_OUT_EN
  function automatic logic [3:0] code(input string s);
    case (s)
      "TLR": return 4'hF;   "RTI": return 4'hC;   "SelDR": return 4'h7;
      "CapDR": return 4'h6; "ShDR": return 4'h2;  "Ex1DR": return 4'h1;
      "PauseDR": return 4'h3; "Ex2DR": return 4'h0; "UpdDR": return 4'h5;
      "SelIR": return 4'h4; "CapIR": return 4'hE; "ShIR": return 4'hA;
      "Ex1IR": return 4'h9; "PauseIR": return 4'hB; "Ex2IR": return 4'h8;
      default: return 4'hD;
    endcase
  endfunction
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = "TLR";
    m_ir    = 2'b00;
    m_instr = 2'd3;
    m_tdo   = 1'b0;
    m_tdoEn = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".instruction"}, instruction, m_instr);
    chk({tag, ".captureDR"},   captureDR,   m_state == "CapDR");
    chk({tag, ".shiftDR"},     shiftDR,     m_state == "ShDR");
    chk({tag, ".updateDR"},    updateDR,    m_state == "UpdDR");
    chk({tag, ".tdo"},         tdo,         m_tdo);
    chk({tag, ".tdoEn"},       tdoEn,       m_tdoEn);
`ifdef TAP_STATE_OUT_EN
    chk({tag, ".tapState"},    tapState,    code(m_state));
`endif
  endtask

  task automatic step(input logic t, input logic d, input logic dr);
    logic [1:0] old_ir;
    tms = t; tdi = d; drTdo = dr;
    @(posedge clk);
    old_ir  = m_ir;
    m_tdo   = 1'b0;
    m_tdoEn = 1'b0;
    if (m_state == "ShIR") begin
      m_tdo = old_ir[0]; m_tdoEn = 1'b1;
    end else if (m_state == "ShDR") begin
      m_tdo = dr; m_tdoEn = 1'b1;
    end
    if (m_state == "CapIR")     m_ir = 2'b01;
    else if (m_state == "ShIR") m_ir = {d, old_ir[1]};
    if (m_state == "UpdIR")     m_instr = old_ir;
    else if (m_state == "TLR")  m_instr = 2'd3;
    m_state = nxt(m_state, t);
    #1;
    check_all(m_state);
  endtask

  initial begin
    rst = 1'b1; tms = 1'b0; tdi = 1'b0; drTdo = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    #1 rst = 1'b0;

    // IR load: TLR -> Shift-IR, shift 0 then 1, update -> INTEST
    step(0, 0, 0); step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    chk("ir_unchanged_in_shift", instruction, 2'd3);
    step(0, 0, 0);
    chk("ir_capture_bit0", tdo, 1'b1);
    chk("ir_capture_en0", tdoEn, 1'b1);
    step(1, 1, 0);
    chk("ir_capture_bit1", tdo, 1'b0);
    step(1, 0, 0);
    chk("ir_before_update", instruction, 2'd3);
    step(0, 0, 0);
    chk("ir_load_intest", instruction, 2'd2);

    // DR scan from RTI
    step(1, 0, 0); step(0, 0, 0);
    chk("dr_capture", captureDR, 1'b1);
    step(0, 0, 0);
    chk("dr_shift", shiftDR, 1'b1);
    step(0, 0, 1); chk("dr_tdo1", tdo, 1'b1);
    step(0, 0, 0); chk("dr_tdo0", tdo, 1'b0);
    step(1, 0, 1); chk("dr_tdo2", tdo, 1'b1);
    step(1, 0, 0); chk("dr_update", updateDR, 1'b1);
    step(0, 0, 0); chk("dr_update_pulse", updateDR, 1'b0);

    // Pause in Shift-IR holds irShift
    step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    step(0, 1, 0); step(1, 0, 0);
    step(0, 0, 0); chk("pause_tdoen", tdoEn, 1'b0);
    step(0, 0, 0); step(0, 0, 0);
    step(1, 0, 0); step(0, 0, 0);
    step(0, 0, 0); chk("pause_resume_bit", tdo, 1'b1);
    step(1, 0, 0); chk("pause_resume_en", tdoEn, 1'b1);
    step(1, 0, 0); step(0, 0, 0);
    chk("pause_load_extest", instruction, 2'd0);

    // Escape from Shift-DR with tms held high
    step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 1);
    chk("escape_not_yet", instruction, 2'd0);
    step(1, 0, 0);
    chk("escape_bypass", instruction, 2'd3);

    // Load EXTEST again, then reset asynchronously in mid-Shift-IR
    step(0, 0, 0); step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    step(0, 0, 0); step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);
    chk("reload_extest", instruction, 2'd0);
    step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0); step(0, 1, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_instr", instruction, 2'd3);
    check_all("async_rst");
    #1 rst = 1'b0;

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("rand_rst");
        #1 rst = 1'b0;
      end
      step(($urandom_range(0, 99) < 35), $urandom_range(0, 1), $urandom_range(0, 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
